cbus_rr_arbiter: RTL and testbench

Parametrised N-host arbiter for the cached-bus (CBus) path. It multiplexes N `cbus_req_t` request ports onto one `cbus_req_t` output toward the address translator and memory. It is the successor of the fixed two-port instruction/data arbiter, and adds three things: configurable port count, a selectable fixed-priority or round-robin policy, and debug visibility of the current owner. It sits between the per-host bus converters (IBus/DBus→CBus, buffers, uncached paths) and the address translator at SoC top level.

---
 rtl/cbus_rr_arbiter_pkg.sv | 38 +++
 rtl/cbus_rr_arbiter_if.sv | 28 ++
 rtl/cbus_rr_arbiter_rr_pick.sv | 31 +++
 rtl/cbus_rr_arbiter.sv | 95 +++++++++
 tb/tb_cbus_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// CBus typedefs shared by the host-side converters and the arbiter.
// Also carries the arbitration policy enum and owner-width helper.
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_t;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_t;

    localparam int ARB_MAX_PORTS = 8;

    // Owner index width; a single port still gets a 1-bit index.
    function automatic int own_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Host-side and downstream CBus bundle seen by the arbiter.
// slave: arbiter view; master: hosts plus downstream memory view.
interface cbus_rr_arbiter_if
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int N_PORTS = 2
) ();

    cbus_req_t  [N_PORTS-1:0] ireqs;
    cbus_resp_t [N_PORTS-1:0] iresps;
    cbus_req_t                oreq;
    cbus_resp_t               oresp;

    modport slave (
        input  ireqs,
        output iresps,
        output oreq,
        input  oresp
    );

    modport master (
        output ireqs,
        input  iresps,
        input  oreq,
        output oresp
    );

endinterface

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational priority picker: first set request at or after start,
// wrapping modulo N. A start of zero gives plain fixed priority.
module rr_pick
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int N = 2,
    parameter int W = own_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] pos;

    // Walk the N positions from start, keep the first requester.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = W'((int'(start_i) + k) % N);
            if (!found_o && req_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-host CBus arbiter, fixed-priority or round-robin policy.
// Grant is held from selection until the downstream last beat.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int        N_PORTS = 2,
    parameter arb_mode_t MODE    = ARB_FIXED,
    localparam int       OWN_W   = own_w(N_PORTS)
) (
    input  logic             clk,
    input  logic             reset,
    cbus_rr_arbiter_if.slave bus,
    output logic             busy,
    output logic [OWN_W-1:0] owner
);

    arb_state_t       state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [OWN_W-1:0] start;
    logic [OWN_W-1:0] win;
    logic [OWN_W-1:0] next_ptr;
    logic [N_PORTS-1:0] req_vld;
    logic             found;
    logic             last_beat;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_vld
        assign req_vld[g] = bus.ireqs[g].valid;
    end

    assign start     = (MODE == ARB_RR) ? rr_ptr_q : '0;
    assign last_beat = bus.oresp.ready && bus.oresp.last;
    assign next_ptr  = (owner_q == OWN_W'(N_PORTS - 1))
                     ? '0 : owner_q + OWN_W'(1);

    rr_pick #(
        .N (N_PORTS),
        .W (OWN_W)
    ) u_pick (
        .req_i   (req_vld),
        .start_i (start),
        .found_o (found),
        .idx_o   (win)
    );

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Grant on any request in IDLE; release and advance pointer on last.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_BUSY;
                    owner_d = win;
                end
            end
            ST_BUSY: begin
                if (last_beat) begin
                    state_d = ST_IDLE;
                    if (MODE == ARB_RR) begin
                        rr_ptr_d = next_ptr;
                    end
                end
            end
        endcase
    end

    // Route the owner's request down and the response back to it only.
    always_comb begin
        bus.oreq   = '0;
        bus.iresps = '0;
        if (state_q == ST_BUSY) begin
            bus.oreq            = bus.ireqs[owner_q];
            bus.iresps[owner_q] = bus.oresp;
        end
    end

    assign busy  = (state_q == ST_BUSY);
    assign owner = owner_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter across port counts and policies.
// Outputs are sampled a couple of time units after the rising edge.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cbus_rr_arbiter_if #(.N_PORTS(2)) b2 ();
    cbus_rr_arbiter_if #(.N_PORTS(4)) b4 ();
    cbus_rr_arbiter_if #(.N_PORTS(3)) b3f ();
    cbus_rr_arbiter_if #(.N_PORTS(3)) b3r ();
    cbus_rr_arbiter_if #(.N_PORTS(1)) b1 ();

    logic       busy2, busy4, busy3f, busy3r, busy1;
    logic [0:0] own2, own1;
    logic [1:0] own4, own3f, own3r;

    cbus_rr_arbiter #(.N_PORTS(2), .MODE(ARB_FIXED)) u2 (
        .clk(clk), .reset(reset), .bus(b2), .busy(busy2), .owner(own2));
    cbus_rr_arbiter #(.N_PORTS(4), .MODE(ARB_RR)) u4 (
        .clk(clk), .reset(reset), .bus(b4), .busy(busy4), .owner(own4));
    cbus_rr_arbiter #(.N_PORTS(3), .MODE(ARB_FIXED)) u3f (
        .clk(clk), .reset(reset), .bus(b3f), .busy(busy3f), .owner(own3f));
    cbus_rr_arbiter #(.N_PORTS(3), .MODE(ARB_RR)) u3r (
        .clk(clk), .reset(reset), .bus(b3r), .busy(busy3r), .owner(own3r));
    cbus_rr_arbiter #(.N_PORTS(1), .MODE(ARB_FIXED)) u1 (
        .clk(clk), .reset(reset), .bus(b1), .busy(busy1), .owner(own1));

    function automatic cbus_req_t mk(input logic [31:0] a, input logic [3:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = a[8];
        r.size     = 3'd2;
        r.addr     = a;
        r.strobe   = 4'hf;
        r.data     = ~a;
        r.len      = len;
        return r;
    endfunction

    function automatic cbus_resp_t mkr(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b2.ireqs = '0;  b2.oresp = '0;
        b3f.ireqs = '0; b3f.oresp = '0;
        b3r.ireqs = '0; b3r.oresp = '0;
        b1.ireqs = '0;  b1.oresp = '0;
        for (int i = 0; i < 4; i++) b4.ireqs[i] = mk(32'h100 + i, 4'd0);
        b4.oresp = mkr(1'b1, 1'b1, 32'h1);
        tick(); tick(); #1;
        n_cmp++; if ({busy2, busy4, busy3f, busy3r, busy1} !== 5'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 00000", {busy2, busy4, busy3f, busy3r, busy1}); end
        n_cmp++; if (own4 !== 2'd0) begin n_bad++; $display("FAIL rst_owner: got %0d want 0", own4); end
        n_cmp++; if (b4.oreq !== '0) begin n_bad++; $display("FAIL rst_oreq: got %h want 0", b4.oreq); end
        n_cmp++; if (b4.iresps !== '0) begin n_bad++; $display("FAIL rst_iresps: got %h want 0", b4.iresps); end
        b4.ireqs = '0;
        b4.oresp = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fixed2();
        cbus_req_t  r0, r1;
        cbus_resp_t rs;
        r0 = mk(32'h1000, 4'd0);
        r1 = mk(32'h2000, 4'd0);
        rs = mkr(1'b1, 1'b1, 32'hA0);
        b2.ireqs[0] = r0; b2.ireqs[1] = r1; b2.oresp = '0; #1;
        n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL fx2_idle_busy: got %b want 0", busy2); end
        n_cmp++; if (b2.oreq.valid !== 1'b0) begin n_bad++; $display("FAIL fx2_idle_oreq: got %b want 0", b2.oreq.valid); end
        tick(); #1;
        n_cmp++; if (busy2 !== 1'b1) begin n_bad++; $display("FAIL fx2_g0_busy: got %b want 1", busy2); end
        n_cmp++; if (own2 !== 1'b0) begin n_bad++; $display("FAIL fx2_g0_owner: got %0d want 0", own2); end
        n_cmp++; if (b2.oreq !== r0) begin n_bad++; $display("FAIL fx2_g0_oreq: got %h want %h", b2.oreq, r0); end
        b2.oresp = rs; #1;
        n_cmp++; if (b2.iresps[0] !== rs) begin n_bad++; $display("FAIL fx2_g0_resp: got %h want %h", b2.iresps[0], rs); end
        n_cmp++; if (b2.iresps[1] !== '0) begin n_bad++; $display("FAIL fx2_g0_other: got %h want 0", b2.iresps[1]); end
        tick();
        b2.ireqs[0] = '0; b2.oresp = '0; #1;
        n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL fx2_bubble_busy: got %b want 0", busy2); end
        n_cmp++; if (b2.oreq.valid !== 1'b0) begin n_bad++; $display("FAIL fx2_bubble_oreq: got %b want 0", b2.oreq.valid); end
        tick(); #1;
        n_cmp++; if (own2 !== 1'b1) begin n_bad++; $display("FAIL fx2_g1_owner: got %0d want 1", own2); end
        n_cmp++; if (b2.oreq !== r1) begin n_bad++; $display("FAIL fx2_g1_oreq: got %h want %h", b2.oreq, r1); end
        b2.oresp = rs; #1;
        n_cmp++; if (b2.iresps[1] !== rs) begin n_bad++; $display("FAIL fx2_g1_resp: got %h want %h", b2.iresps[1], rs); end
        n_cmp++; if (b2.iresps[0] !== '0) begin n_bad++; $display("FAIL fx2_g1_other: got %h want 0", b2.iresps[0]); end
        tick();
        b2.ireqs[1] = '0; b2.oresp = '0; #1;
        n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL fx2_end_busy: got %b want 0", busy2); end
    endtask

    task automatic test_rr4();
        cbus_req_t r[4];
        for (int i = 0; i < 4; i++) begin
            r[i] = mk(32'h4000 + 32'(i * 16), 4'd0);
            b4.ireqs[i] = r[i];
        end
        b4.oresp = mkr(1'b1, 1'b1, 32'hB0); #1;
        for (int g = 0; g < 5; g++) begin
            tick(); #1;
            n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL rr4_busy_%0d: got %b want 1", g, busy4); end
            n_cmp++; if (own4 !== 2'(g % 4)) begin n_bad++; $display("FAIL rr4_owner_%0d: got %0d want %0d", g, own4, g % 4); end
            n_cmp++; if (b4.oreq !== r[g % 4]) begin n_bad++; $display("FAIL rr4_oreq_%0d: got %h want %h", g, b4.oreq, r[g % 4]); end
            tick(); #1;
            n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL rr4_bubble_%0d: got %b want 0", g, busy4); end
            n_cmp++; if (b4.oreq.valid !== 1'b0) begin n_bad++; $display("FAIL rr4_bvalid_%0d: got %b want 0", g, b4.oreq.valid); end
        end
        b4.ireqs = '0;
        b4.oresp = '0;
    endtask

    task automatic test_burst();
        cbus_req_t  r2, r3;
        cbus_resp_t rs;
        int         pulses;
        r2 = mk(32'h5200, 4'd3);
        r3 = mk(32'h5300, 4'd0);
        b4.ireqs[2] = r2; b4.ireqs[3] = r3; b4.oresp = '0; #1;
        tick(); #1;
        n_cmp++; if (own4 !== 2'd2) begin n_bad++; $display("FAIL bst_owner: got %0d want 2", own4); end
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            rs = mkr(1'b1, b == 3, 32'hC0 + 32'(b));
            b4.oresp = rs; #1;
            n_cmp++; if (b4.oreq !== r2) begin n_bad++; $display("FAIL bst_oreq_%0d: got %h want %h", b, b4.oreq, r2); end
            n_cmp++; if (b4.iresps[2] !== rs) begin n_bad++; $display("FAIL bst_resp_%0d: got %h want %h", b, b4.iresps[2], rs); end
            n_cmp++; if ({b4.iresps[0], b4.iresps[1], b4.iresps[3]} !== '0) begin n_bad++; $display("FAIL bst_other_%0d: got %h want 0", b, {b4.iresps[0], b4.iresps[1], b4.iresps[3]}); end
            pulses += int'(b4.iresps[2].ready);
            tick();
        end
        b4.ireqs[2] = '0; b4.oresp = '0; #1;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL bst_bubble: got %b want 0", busy4); end
        pulses += int'(b4.iresps[2].ready);
        n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL bst_pulses: got %0d want 4", pulses); end
        tick(); #1;
        n_cmp++; if (own4 !== 2'd3) begin n_bad++; $display("FAIL bst_next_owner: got %0d want 3", own4); end
        n_cmp++; if (b4.oreq !== r3) begin n_bad++; $display("FAIL bst_next_oreq: got %h want %h", b4.oreq, r3); end
        b4.oresp = mkr(1'b1, 1'b1, 32'hC9);
        tick();
        b4.ireqs[3] = '0; b4.oresp = '0; #1;
    endtask

    task automatic test_async_reset();
        cbus_req_t r1;
        b4.ireqs[2] = mk(32'h6200, 4'd0); #1;
        tick(); #1;
        n_cmp++; if (own4 !== 2'd2) begin n_bad++; $display("FAIL ar_pre_owner: got %0d want 2", own4); end
        b4.oresp = mkr(1'b1, 1'b1, 32'hD0);
        tick();
        b4.ireqs[2] = '0; b4.oresp = '0;
        r1 = mk(32'h6100, 4'd3);
        b4.ireqs[1] = r1; #1;
        tick(); #1;
        n_cmp++; if (own4 !== 2'd1) begin n_bad++; $display("FAIL ar_burst_owner: got %0d want 1", own4); end
        b4.oresp = mkr(1'b1, 1'b0, 32'hD1);
        tick(); #1;
        n_cmp++; if (b4.oreq.valid !== 1'b1) begin n_bad++; $display("FAIL ar_beat2_valid: got %b want 1", b4.oreq.valid); end
        reset = 1'b1; #1;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL ar_busy: got %b want 0", busy4); end
        n_cmp++; if (b4.oreq.valid !== 1'b0) begin n_bad++; $display("FAIL ar_oreq: got %b want 0", b4.oreq.valid); end
        n_cmp++; if (own4 !== 2'd0) begin n_bad++; $display("FAIL ar_owner: got %0d want 0", own4); end
        n_cmp++; if (b4.iresps !== '0) begin n_bad++; $display("FAIL ar_iresps: got %h want 0", b4.iresps); end
        b4.ireqs[3] = mk(32'h6300, 4'd0);
        b4.oresp = '0;
        tick(); tick();
        reset = 1'b0; #1;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL ar_idle: got %b want 0", busy4); end
        n_cmp++; if (b4.oreq.valid !== 1'b0) begin n_bad++; $display("FAIL ar_idle_oreq: got %b want 0", b4.oreq.valid); end
        tick(); #1;
        n_cmp++; if (own4 !== 2'd1) begin n_bad++; $display("FAIL ar_rrptr: got %0d want 1", own4); end
        b4.oresp = mkr(1'b1, 1'b1, 32'hD2);
        tick();
        b4.ireqs = '0; b4.oresp = '0; #1;
    endtask

    task automatic test_starvation();
        cbus_req_t ra, rc;
        logic [1:0] exp_rr;
        ra = mk(32'h7000, 4'd0);
        rc = mk(32'h7200, 4'd0);
        b3f.ireqs[0] = ra; b3f.ireqs[1] = '0; b3f.ireqs[2] = rc;
        b3r.ireqs[0] = ra; b3r.ireqs[1] = '0; b3r.ireqs[2] = rc;
        b3f.oresp = mkr(1'b1, 1'b1, 32'hE0);
        b3r.oresp = mkr(1'b1, 1'b1, 32'hE0); #1;
        for (int t = 0; t < 4; t++) begin
            exp_rr = (t % 2 == 0) ? 2'd0 : 2'd2;
            tick(); #1;
            n_cmp++; if (busy3f !== 1'b1 || own3f !== 2'd0) begin n_bad++; $display("FAIL stv_fixed_%0d: got busy %b owner %0d want busy 1 owner 0", t, busy3f, own3f); end
            n_cmp++; if (busy3r !== 1'b1 || own3r !== exp_rr) begin n_bad++; $display("FAIL stv_rr_%0d: got busy %b owner %0d want busy 1 owner %0d", t, busy3r, own3r, exp_rr); end
            tick(); #1;
            n_cmp++; if ({busy3f, busy3r} !== 2'b00) begin n_bad++; $display("FAIL stv_bubble_%0d: got %b want 00", t, {busy3f, busy3r}); end
        end
        b3f.ireqs = '0; b3r.ireqs = '0;
        b3f.oresp = '0; b3r.oresp = '0; #1;
    endtask

    task automatic test_single();
        cbus_req_t  ra, rb, rc;
        cbus_resp_t rs;
        ra = mk(32'h8000, 4'd0);
        rb = mk(32'h8100, 4'd7);
        rc = mk(32'h8200, 4'd0);
        b1.ireqs[0] = ra; b1.oresp = '0; #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL one_idle: got %b want 0", busy1); end
        tick(); #1;
        n_cmp++; if (busy1 !== 1'b1 || own1 !== 1'b0) begin n_bad++; $display("FAIL one_ga: got busy %b owner %0d want 1/0", busy1, own1); end
        n_cmp++; if (b1.oreq !== ra) begin n_bad++; $display("FAIL one_ga_oreq: got %h want %h", b1.oreq, ra); end
        rs = mkr(1'b1, 1'b1, 32'hF0);
        b1.oresp = rs; #1;
        n_cmp++; if (b1.iresps[0] !== rs) begin n_bad++; $display("FAIL one_ga_resp: got %h want %h", b1.iresps[0], rs); end
        tick();
        b1.ireqs[0] = rb; b1.oresp = '0; #1;
        n_cmp++; if (busy1 !== 1'b0 || b1.oreq.valid !== 1'b0) begin n_bad++; $display("FAIL one_bubble1: got busy %b valid %b want 0/0", busy1, b1.oreq.valid); end
        tick(); #1;
        for (int b = 0; b < 8; b++) begin
            rs = mkr(1'b1, b == 7, 32'hF1 + 32'(b));
            b1.oresp = rs; #1;
            n_cmp++; if (busy1 !== 1'b1 || own1 !== 1'b0) begin n_bad++; $display("FAIL one_bst_own_%0d: got busy %b owner %0d want 1/0", b, busy1, own1); end
            n_cmp++; if (b1.oreq !== rb) begin n_bad++; $display("FAIL one_bst_oreq_%0d: got %h want %h", b, b1.oreq, rb); end
            n_cmp++; if (b1.iresps[0] !== rs) begin n_bad++; $display("FAIL one_bst_resp_%0d: got %h want %h", b, b1.iresps[0], rs); end
            tick();
        end
        b1.ireqs[0] = rc; b1.oresp = '0; #1;
        n_cmp++; if (busy1 !== 1'b0 || b1.oreq.valid !== 1'b0) begin n_bad++; $display("FAIL one_bubble2: got busy %b valid %b want 0/0", busy1, b1.oreq.valid); end
        tick(); #1;
        n_cmp++; if (busy1 !== 1'b1 || own1 !== 1'b0) begin n_bad++; $display("FAIL one_gc: got busy %b owner %0d want 1/0", busy1, own1); end
        n_cmp++; if (b1.oreq !== rc) begin n_bad++; $display("FAIL one_gc_oreq: got %h want %h", b1.oreq, rc); end
        b1.oresp = mkr(1'b1, 1'b1, 32'hFF);
        tick();
        b1.ireqs[0] = '0; b1.oresp = '0; #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL one_end: got %b want 0", busy1); end
    endtask

    initial begin
        test_reset();
        test_fixed2();
        test_rr4();
        test_burst();
        test_async_reset();
        test_starvation();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
